// File: rtl/seq_det_sched_if.sv
// Bus between the serial requesters / result collector and seq_det_sched.
// The slave modport is the scheduler's view; master is the environment's view.
interface seq_det_sched_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 5
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  bit_in;
    logic [NREQ-1:0]  gnt;
    logic             busy;
    logic             done;
    logic [IW-1:0]    done_id;
    logic [CNT_W-1:0] match_cnt;

    modport slave (
        input  req, bit_in,
        output gnt, busy, done, done_id, match_cnt
    );

    modport master (
        output req, bit_in,
        input  gnt, busy, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin time-sharing of one overlapping 4-bit pattern detector across
// NREQ serial requesters; one FRAME_LEN-bit frame per grant, then a report.
module seq_det_sched #(
    parameter int         NREQ      = 4,
    parameter int         FRAME_LEN = 16,
    parameter logic [3:0] PATTERN   = 4'b1101,
    parameter int         CNT_W     = 5
) (
    input  logic          clk,
    input  logic          reset,
    seq_det_sched_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [2:0]       hist_q, hist_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             done_q, done_d;
    logic [IW-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic [IW-1:0]    pick_id;
    logic             found;
    logic [IW-1:0]    rr_nxt;
    logic             b;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;

    // First requester at or above rr_q, wrapping; lowest rotation offset wins.
    always_comb begin
        int idx;
        pick_id = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[IW'(idx)]) begin
                found   = 1'b1;
                pick_id = IW'(idx);
            end
        end
    end

    assign rr_nxt  = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + IW'(1);
    assign b       = bus.bit_in[sel_q];
    // History is cleared per frame, so the first three bits must not match.
    assign hit     = (bcnt_q >= 8'd3) && ({hist_q, b} == PATTERN);
    assign cnt_inc = (hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        hist_d    = hist_q;
        bcnt_d    = bcnt_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        mcnt_d    = mcnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_SCAN;
                    sel_d   = pick_id;
                    gnt_d   = NREQ'(1) << pick_id;
                    hist_d  = '0;
                    bcnt_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_SCAN: begin
                if (!bus.req[sel_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    rr_d    = rr_nxt;
                end else begin
                    hist_d = {hist_q[1:0], b};
                    bcnt_d = bcnt_q + 8'd1;
                    cnt_d  = cnt_inc;
                    if (bcnt_q == 8'(FRAME_LEN - 1)) begin
                        state_d   = S_REPORT;
                        gnt_d     = '0;
                        done_d    = 1'b1;
                        done_id_d = sel_q;
                        mcnt_d    = cnt_inc;
                    end
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
                rr_d    = rr_nxt;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            rr_q      <= '0;
            hist_q    <= '0;
            bcnt_q    <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            mcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            hist_q    <= hist_d;
            bcnt_q    <= bcnt_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = mcnt_q;
endmodule

// File: tb/tb_seq_det_sched.sv
// Directed/randomized bench for seq_det_sched against a frame-level model
// (window counting over the frame, round-robin pick by rotation search).
module tb_seq_det_sched;
    localparam int NREQ = 4;
    localparam int FL   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_det_sched_if #(.NREQ(NREQ), .CNT_W(5)) bus ();
    seq_det_sched_if #(.NREQ(NREQ), .CNT_W(2)) bus2 ();

    assign bus2.req    = bus.req;
    assign bus2.bit_in = bus.bit_in;

    seq_det_sched #(.NREQ(NREQ), .FRAME_LEN(FL), .PATTERN(4'b1101), .CNT_W(5)) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave));

    seq_det_sched #(.NREQ(NREQ), .FRAME_LEN(FL), .PATTERN(4'b1101), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int rr    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count 4-bit windows equal to 1101 (MSB of f is the first bit), saturating.
    function automatic int model_matches(input logic [15:0] f, input int cw);
        int c;
        logic [3:0] w;
        c = 0;
        for (int i = 0; i <= FL - 4; i++) begin
            w = f[15-i -: 4];
            if (w == 4'b1101 && c < (1 << cw) - 1) c++;
        end
        return c;
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // Called in IDLE just after an edge; req is seen at the next edge.
    task automatic run_frame(input logic [3:0] reqv, input logic [15:0] f);
        int ch;
        ch = pick(reqv, rr);
        bus.req = reqv;
        step();
        chk("gnt_rise", 32'(bus.gnt), 32'(1 << ch));
        chk("busy_scan", 32'(bus.busy), 32'd1);
        for (int i = 0; i < FL; i++) begin
            bus.bit_in = 4'($urandom);
            bus.bit_in[ch] = f[15-i];
            step();
            if (i < FL - 1) begin
                chk("gnt_hold", 32'(bus.gnt), 32'(1 << ch));
                chk("no_early_done", 32'(bus.done), 32'd0);
            end
        end
        chk("done", 32'(bus.done), 32'd1);
        chk("done_id", 32'(bus.done_id), 32'(ch));
        chk("match_cnt", 32'(bus.match_cnt), 32'(model_matches(f, 5)));
        chk("match_cnt_sat", 32'(bus2.match_cnt), 32'(model_matches(f, 2)));
        chk("gnt_report", 32'(bus.gnt), 32'd0);
        chk("busy_report", 32'(bus.busy), 32'd1);
        rr = (ch + 1) % NREQ;
        step();
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("gnt_idle", 32'(bus.gnt), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("done_id_hold", 32'(bus.done_id), 32'(ch));
    endtask

    initial begin
        logic [15:0] f;
        int ch;
        reset      = 1'b0;
        bus.req    = '0;
        bus.bit_in = '0;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_done_id", 32'(bus.done_id), 32'd0);
        chk("rst_match", 32'(bus.match_cnt), 32'd0);
        reset = 1'b1;
        step();
        chk("idle_no_req", 32'(bus.busy), 32'd0);

        // Fairness: all request, all-ones data -> 0,1,2,3,0 with zero matches
        for (int k = 0; k < 5; k++) run_frame(4'b1111, 16'hFFFF);
        bus.req = '0;
        step();

        // Frame isolation: ch1 tail 110, ch2 frame 1101 then zeros
        f = 16'($urandom);
        f[2:0] = 3'b110;
        run_frame(4'b0110, f);
        run_frame(4'b0110, 16'hD000);
        bus.req = '0;
        step();

        // Pattern train: 5 matches, 3 when saturated at CNT_W=2
        run_frame(4'b0001, 16'b1101101101101101);
        bus.req = '0;
        step();

        // Abort: req[0] drops in the 6th scan cycle
        ch = pick(4'b0001, rr);
        bus.req = 4'b0001;
        step();
        chk("abort_gnt", 32'(bus.gnt), 32'(1 << ch));
        for (int i = 0; i < 5; i++) begin
            bus.bit_in = 4'($urandom);
            step();
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        bus.req = 4'b0000;
        step();
        chk("abort_gnt_off", 32'(bus.gnt), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        rr = (ch + 1) % NREQ;
        run_frame(4'b0011, 16'($urandom));
        bus.req = '0;
        step();

        // Random frames with random request masks
        for (int k = 0; k < 6; k++) run_frame(4'($urandom_range(1, 15)), 16'($urandom));
        run_frame(4'b0001, 16'b1101101101101101);

        // Reset during the 10th scan cycle
        ch = pick(4'b0100, rr);
        bus.req = 4'b0100;
        step();
        for (int i = 0; i < 9; i++) begin
            bus.bit_in = 4'($urandom);
            step();
        end
        #2;
        reset = 1'b0;
        #1;
        chk("arst_gnt", 32'(bus.gnt), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_match", 32'(bus.match_cnt), 32'd0);
        bus.req = 4'b0011;
        step();
        step();
        chk("arst_hold_gnt", 32'(bus.gnt), 32'd0);
        reset = 1'b1;
        rr = 0;
        run_frame(4'b0011, 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Round-robin scheduler that time-shares one overlapping 4-bit pattern detector among NREQ serial requesters.
- Grants one requester for a fixed frame of FRAME_LEN bits and muxes that requester's serial bit into the detector.
- Counts pattern matches within the frame, then reports the channel id and match count.
- Sits between serial sources and the downstream result collector; the detector history is cleared per frame so channels never cross-contaminate.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FRAME_LEN, 16, bits scanned per grant (4..255).
- PATTERN, 4'b1101, detected sequence; MSB is the earliest bit; overlapping matches count.
- CNT_W, 5, width of the match counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-channel request; held high until done for that channel.
- bit_in  input  NREQ  per-channel serial data; sampled only for the granted channel.
- gnt  output  NREQ  one-hot grant (all zero when not scanning).
- busy  output  1  high while in SCAN or REPORT.
- done  output  1  single-cycle pulse: frame complete.
- done_id  output  max(1,$clog2(NREQ))  channel of the completed frame; valid with done.
- match_cnt  output  CNT_W  matches in the completed frame; valid with done.

Behaviour:
- Reset (reset=0, asynchronous) forces all of the following: state=IDLE, gnt=0, busy=0, done=0, done_id=0, match_cnt=0, rr_ptr=0, history=0, bit counter=0, running count=0. Reset asserted mid-frame aborts the frame immediately with no done pulse.
- States: IDLE, SCAN, REPORT.
- IDLE:
  - If req != 0, select the first set bit searching upward from rr_ptr, with wrap-around.
  - Next cycle: state=SCAN, gnt=onehot(sel), busy=1, history, bit counter and running count cleared.
  - If req == 0, stay in IDLE.
- SCAN (one bit per cycle):
  - On each clock edge, sample b=bit_in[sel] and shift history (3 bits) left by b; the bit counter increments.
  - Match when at least 4 bits of this frame have been sampled, including b, and {history,b}==PATTERN. A match increments the running count, saturating at 2^CNT_W-1.
  - The edge that samples bit FRAME_LEN moves to REPORT. The count includes that last bit's match.
- Abort: if req[sel] is low in any SCAN cycle, that cycle's bit is not sampled.
  - Next state is IDLE with gnt=0 and no done pulse.
  - rr_ptr=sel+1 (mod NREQ).
- REPORT (exactly 1 cycle):
  - gnt=0, done=1, done_id=sel, match_cnt=final count, busy=1.
  - rr_ptr=sel+1 (mod NREQ); next state is IDLE.
  - done_id and match_cnt hold their values until the next done pulse.
- Latency: req seen in IDLE at edge k gives gnt high after edge k. Bits are sampled at edges k+1..k+FRAME_LEN. done is high after edge k+FRAME_LEN for one cycle.
- Back-to-back: after REPORT the block spends one IDLE cycle, so a new grant rises 2 cycles after done rises.
- Exactly one gnt bit is high during SCAN. gnt never changes mid-frame, even if higher-priority requests arrive.
- bit_in of non-granted channels is ignored.
- Simultaneous requests are resolved only by rr_ptr order.

Test Plan:
- Single channel, pattern train: req=0001, channel 0 streams 1101101101101101 (FRAME_LEN=16) -> gnt=0001 for 16 cycles, then done=1, done_id=0, match_cnt=5; gnt=0 in the done cycle.
- Round-robin fairness: req=1111 held, each channel streams all-ones -> grants in order 0,1,2,3,0. Each done reports match_cnt=0, and there are exactly 2 cycles from done rise to the next gnt rise.
- Frame isolation: channel 1 ends its frame with ...110; channel 2 starts its frame with 1... -> channel 2 reports no match attributable to channel 1's tail (history cleared). Channel 2 frame 1101 followed by 0s reports match_cnt=1.
- Saturation: CNT_W=2, channel 0 streams 1101101101101101 -> match_cnt=3.
- Abort: req[0] drops at the 6th SCAN cycle -> gnt=0 on the next edge, no done pulse, and the next grant goes to channel 1 if requesting.
- Reset mid-frame: reset=0 during the 10th SCAN cycle -> gnt, busy, done and match_cnt all 0 immediately (asynchronously). After release with req=0011, the first grant is channel 0.
